// File: rtl/timer_ctrl.sv
// timer_ctrl: sequencing controller for a repeating up-counter timer
module timer_ctrl #(
  parameter int CNT_W = 32,
  parameter int REP_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             stop,
  input  logic [CNT_W-1:0] cfg_max_i,
  input  logic [REP_W-1:0] cfg_reps_i,
  input  logic             irq_per_en,
  input  logic             irq_clr,
  input  logic [CNT_W-1:0] tmr_cnt,
  output logic             tmr_en,
  output logic [CNT_W-1:0] tmr_max,
  output logic             period_pulse,
  output logic             done_pulse,
  output logic             irq,
  output logic             busy,
  output logic [REP_W-1:0] reps_left
);
  localparam logic [1:0] IDLE = 2'd0, RUN = 2'd1, RESTART = 2'd2;
  logic [1:0]       state_q, state_d;
  logic             tmr_en_q, tmr_en_d;
  logic [CNT_W-1:0] tmr_max_q, tmr_max_d;
  logic [REP_W-1:0] reps_q, reps_d;
  logic             per_q, per_d, done_q, done_d, irq_q, irq_d, busy_q;
  logic             term;
  assign term = (state_q == RUN) && tmr_en_q && (tmr_cnt >= tmr_max_q);
  // Next state: stop beats start beats terminal count; RESTART spends one
  // cycle with the enable low so the counter is cleared before relatching.
  always_comb begin
    state_d   = state_q;
    tmr_en_d  = tmr_en_q;
    tmr_max_d = tmr_max_q;
    reps_d    = reps_q;
    per_d     = 1'b0;
    done_d    = 1'b0;
    if (stop) begin
      state_d  = IDLE;
      tmr_en_d = 1'b0;
      reps_d   = '0;
      per_d    = term;
    end else if (start && state_q == IDLE) begin
      state_d   = RUN;
      tmr_en_d  = 1'b1;
      tmr_max_d = cfg_max_i;
      reps_d    = cfg_reps_i;
    end else if (start && state_q == RUN) begin
      state_d  = RESTART;
      tmr_en_d = 1'b0;
    end else if (state_q == RESTART) begin
      state_d   = RUN;
      tmr_en_d  = 1'b1;
      tmr_max_d = cfg_max_i;
      reps_d    = cfg_reps_i;
    end else if (term) begin
      per_d = 1'b1;
      if (reps_q == REP_W'(1)) begin
        state_d  = IDLE;
        tmr_en_d = 1'b0;
        reps_d   = '0;
        done_d   = 1'b1;
      end else begin
        tmr_max_d = cfg_max_i;
        reps_d    = (reps_q == '0) ? reps_q : reps_q - REP_W'(1);
      end
    end
    irq_d = done_d | (per_d & irq_per_en) | (irq_q & ~irq_clr);
  end
  // State and output registers, cleared asynchronously
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      tmr_en_q  <= 1'b0;
      tmr_max_q <= '0;
      reps_q    <= '0;
      per_q     <= 1'b0;
      done_q    <= 1'b0;
      irq_q     <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      tmr_en_q  <= tmr_en_d;
      tmr_max_q <= tmr_max_d;
      reps_q    <= reps_d;
      per_q     <= per_d;
      done_q    <= done_d;
      irq_q     <= irq_d;
      busy_q    <= (state_d != IDLE);
    end
  end
  assign tmr_en       = tmr_en_q;
  assign tmr_max      = tmr_max_q;
  assign period_pulse = per_q;
  assign done_pulse   = done_q;
  assign irq          = irq_q;
  assign busy         = busy_q;
  assign reps_left    = reps_q;
endmodule

// File: tb/tb_timer_ctrl.sv
// tb_timer_ctrl: directed tests for timer_ctrl driving a behavioural counter
module tb_timer_ctrl;
  logic        clk, rst_n, start, stop, irq_per_en, irq_clr;
  logic [31:0] cfg_max, cnt, tmr_max;
  logic [15:0] cfg_reps, reps_left;
  logic        tmr_en, period_pulse, done_pulse, irq, busy;
  logic [4:0]  st;
  int total = 0, bad = 0;

  timer_ctrl #(.CNT_W(32), .REP_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .stop(stop),
    .cfg_max_i(cfg_max), .cfg_reps_i(cfg_reps), .irq_per_en(irq_per_en),
    .irq_clr(irq_clr), .tmr_cnt(cnt), .tmr_en(tmr_en), .tmr_max(tmr_max),
    .period_pulse(period_pulse), .done_pulse(done_pulse), .irq(irq),
    .busy(busy), .reps_left(reps_left)
  );

  assign st = {tmr_en, busy, period_pulse, done_pulse, irq};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // counter being controlled: cleared while disabled, wraps at max
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt <= '0;
    else cnt <= (!tmr_en || cnt >= tmr_max) ? 32'd0 : cnt + 32'd1;

  task step;
    @(posedge clk);
    #1;
  endtask

  task test_reset;
    rst_n = 1'b0;
    step();
    step();
    total++;
    if (st !== 5'b0 || tmr_max !== 32'd0 || reps_left !== 16'd0) begin
      bad++; $display("FAIL reset_values: st=%b max=%0d reps=%0d want 0 0 0", st, tmr_max, reps_left);
    end
    rst_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      step();
      total++;
      if (st !== 5'b0) begin bad++; $display("FAIL idle_cycle%0d: st=%b want 00000", i, st); end
    end
  endtask

  task test_one_shot;
    cfg_max = 32'd4; cfg_reps = 16'd1;
    start = 1'b1; step(); start = 1'b0;
    total++;
    if (st !== 5'b11000 || tmr_max !== 32'd4 || reps_left !== 16'd1) begin
      bad++; $display("FAIL oneshot_start: st=%b max=%0d reps=%0d want 11000 4 1", st, tmr_max, reps_left);
    end
    repeat (4) step();
    total++;
    if (cnt !== 32'd4 || st !== 5'b11000) begin
      bad++; $display("FAIL oneshot_last: cnt=%0d st=%b want 4 11000", cnt, st);
    end
    step();
    total++;
    if (st !== 5'b00111 || reps_left !== 16'd0) begin
      bad++; $display("FAIL oneshot_done: st=%b reps=%0d want 00111 0", st, reps_left);
    end
    step();
    total++;
    if (st !== 5'b00001) begin bad++; $display("FAIL oneshot_after: st=%b want 00001", st); end
    irq_clr = 1'b1; step(); irq_clr = 1'b0;
    total++;
    if (st !== 5'b00000) begin bad++; $display("FAIL oneshot_irqclr: st=%b want 00000", st); end
  endtask

  task test_n_period;
    int np, nd, dpos;
    int pp[3];
    logic [15:0] rl[3];
    np = 0; nd = 0; dpos = 0;
    cfg_max = 32'd3; cfg_reps = 16'd3;
    start = 1'b1; step(); start = 1'b0;
    cfg_max = 32'd1;
    total++;
    if (tmr_max !== 32'd3 || reps_left !== 16'd3) begin
      bad++; $display("FAIL nper_start: max=%0d reps=%0d want 3 3", tmr_max, reps_left);
    end
    for (int s = 1; s <= 12; s++) begin
      step();
      if (period_pulse) begin
        if (np < 3) begin pp[np] = s; rl[np] = reps_left; end
        np++;
      end
      if (done_pulse) begin nd++; dpos = s; end
    end
    total++;
    if (np !== 3) begin bad++; $display("FAIL nper_count: got %0d want 3", np); end
    else begin
      total++;
      if (pp[0] !== 4 || pp[1] !== 6 || pp[2] !== 8) begin
        bad++; $display("FAIL nper_pos: got %0d %0d %0d want 4 6 8", pp[0], pp[1], pp[2]);
      end
      total++;
      if (rl[0] !== 16'd2 || rl[1] !== 16'd1 || rl[2] !== 16'd0) begin
        bad++; $display("FAIL nper_reps: got %0d %0d %0d want 2 1 0", rl[0], rl[1], rl[2]);
      end
    end
    total++;
    if (nd !== 1 || dpos !== 8) begin bad++; $display("FAIL nper_done: count=%0d pos=%0d want 1 8", nd, dpos); end
    total++;
    if (st !== 5'b00001 || tmr_max !== 32'd1) begin
      bad++; $display("FAIL nper_end: st=%b max=%0d want 00001 1", st, tmr_max);
    end
    irq_clr = 1'b1; step(); irq_clr = 1'b0;
  endtask

  task test_continuous;
    cfg_max = 32'd2; cfg_reps = 16'd0; irq_per_en = 1'b1;
    start = 1'b1; step(); start = 1'b0;
    step(); step();
    total++;
    if (st !== 5'b11000) begin bad++; $display("FAIL cont_pre: st=%b want 11000", st); end
    step();
    total++;
    if (st !== 5'b11101 || reps_left !== 16'd0) begin
      bad++; $display("FAIL cont_first: st=%b reps=%0d want 11101 0", st, reps_left);
    end
    step(); step();
    irq_clr = 1'b1; step(); irq_clr = 1'b0;
    total++;
    if (st !== 5'b11101) begin bad++; $display("FAIL cont_setwins: st=%b want 11101", st); end
    stop = 1'b1; step(); stop = 1'b0;
    total++;
    if (st !== 5'b00001) begin bad++; $display("FAIL cont_stop: st=%b want 00001", st); end
    irq_clr = 1'b1; step(); irq_clr = 1'b0;
    total++;
    if (st !== 5'b00000) begin bad++; $display("FAIL cont_clr: st=%b want 00000", st); end
    irq_per_en = 1'b0;
  endtask

  task test_restart;
    int early;
    early = 0;
    cfg_max = 32'd9; cfg_reps = 16'd2;
    start = 1'b1; step(); start = 1'b0;
    repeat (5) step();
    total++;
    if (cnt !== 32'd5) begin bad++; $display("FAIL rst_cnt5: got %0d want 5", cnt); end
    start = 1'b1; step(); start = 1'b0;
    total++;
    if (st !== 5'b01000) begin bad++; $display("FAIL restart_gap: st=%b want 01000", st); end
    step();
    total++;
    if (st !== 5'b11000 || cnt !== 32'd0 || reps_left !== 16'd2) begin
      bad++; $display("FAIL restart_run: st=%b cnt=%0d reps=%0d want 11000 0 2", st, cnt, reps_left);
    end
    repeat (9) begin step(); if (period_pulse || done_pulse) early++; end
    total++;
    if (early !== 0) begin bad++; $display("FAIL restart_early: pulses=%0d want 0", early); end
    step();
    total++;
    if (st !== 5'b11100 || reps_left !== 16'd1) begin
      bad++; $display("FAIL restart_period: st=%b reps=%0d want 11100 1", st, reps_left);
    end
    stop = 1'b1; step(); stop = 1'b0;
    total++;
    if (st !== 5'b00000 || reps_left !== 16'd0) begin
      bad++; $display("FAIL restart_stop: st=%b reps=%0d want 00000 0", st, reps_left);
    end
  endtask

  task test_corners;
    logic [4:0] exp;
    start = 1'b1; stop = 1'b1; step(); start = 1'b0; stop = 1'b0;
    total++;
    if (st !== 5'b00000) begin bad++; $display("FAIL idle_startstop: st=%b want 00000", st); end
    cfg_max = 32'd5; cfg_reps = 16'd0;
    start = 1'b1; step(); start = 1'b0;
    step();
    start = 1'b1; stop = 1'b1; step(); start = 1'b0; stop = 1'b0;
    total++;
    if (st !== 5'b00000) begin bad++; $display("FAIL run_startstop: st=%b want 00000", st); end
    step();
    total++;
    if (st !== 5'b00000) begin bad++; $display("FAIL run_startstop_after: st=%b want 00000", st); end
    cfg_max = 32'd2; cfg_reps = 16'd2;
    start = 1'b1; step(); start = 1'b0;
    step(); step();
    total++;
    if (cnt !== 32'd2) begin bad++; $display("FAIL stopterm_cnt: got %0d want 2", cnt); end
    stop = 1'b1; step(); stop = 1'b0;
    total++;
    if (st !== 5'b00100 || reps_left !== 16'd0) begin
      bad++; $display("FAIL stop_term: st=%b reps=%0d want 00100 0", st, reps_left);
    end
    cfg_max = 32'd0; cfg_reps = 16'd3;
    start = 1'b1; step(); start = 1'b0;
    for (int s = 1; s <= 4; s++) begin
      step();
      exp = (s < 3) ? 5'b11100 : (s == 3) ? 5'b00111 : 5'b00001;
      total++;
      if (st !== exp) begin bad++; $display("FAIL max0_s%0d: st=%b want %b", s, st, exp); end
    end
    irq_clr = 1'b1; step(); irq_clr = 1'b0;
  endtask

  task test_reset_mid;
    cfg_max = 32'd7; cfg_reps = 16'd0;
    start = 1'b1; step(); start = 1'b0;
    step();
    #2 rst_n = 1'b0;
    #1;
    total++;
    if (st !== 5'b00000 || tmr_max !== 32'd0 || reps_left !== 16'd0) begin
      bad++; $display("FAIL reset_mid: st=%b max=%0d reps=%0d want 00000 0 0", st, tmr_max, reps_left);
    end
    step();
    rst_n = 1'b1;
    step();
    total++;
    if (st !== 5'b00000 || cnt !== 32'd0) begin
      bad++; $display("FAIL reset_mid_after: st=%b cnt=%0d want 00000 0", st, cnt);
    end
  endtask

  initial begin
    start = 1'b0; stop = 1'b0; irq_per_en = 1'b0; irq_clr = 1'b0;
    cfg_max = '0; cfg_reps = '0; rst_n = 1'b0;
    test_reset();
    test_one_shot();
    test_n_period();
    test_continuous();
    test_restart();
    test_corners();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end
endmodule
